// File: rtl/uart_csr_fifo.sv
// UART register bank: TX/RX FIFOs, sticky write-1-to-clear status, interrupt enables, baud and CTRL registers.
// Define UART_LOOPBACK_EN to build CTRL[2] loopback (TX pops feed the RX FIFO).
module uart_csr_fifo #(
  parameter int DATA_W   = 8,
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8,
  parameter int DVSR_W   = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [4:0]        address,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_start,
  input  logic              tx_done,
  output logic [DVSR_W-1:0] dvsr,
  output logic              stop2,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_done,
  output logic              tx_int,
  output logic              rx_int
);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam logic [TX_AW:0] TX_FULL_CNT = (TX_AW+1)'(TX_DEPTH);
  localparam logic [RX_AW:0] RX_FULL_CNT = (RX_AW+1)'(RX_DEPTH);

  // Bus handshake: we/re are single-cycle strobes qualified by address. Writes commit at the
  // posedge, rdata is combinational, and an RXDATA read with re pops only when data is present.
  logic [2:0] index;
  assign index = address[4:2];

  logic [DATA_W-1:0] tx_mem [TX_DEPTH];
  logic [DATA_W-1:0] rx_mem [RX_DEPTH];
  logic [TX_AW-1:0]  tx_wr_ptr, tx_rd_ptr;
  logic [RX_AW-1:0]  rx_wr_ptr, rx_rd_ptr;
  logic [TX_AW:0]    tx_count;
  logic [RX_AW:0]    rx_count;
  logic              tx_empty, tx_full, tx_wr, tx_push, tx_pop;
  logic              rx_empty, rx_full, rx_push, rx_pop;
  logic              rx_in_valid;
  logic [DATA_W-1:0] rx_in_data, rx_head;
  logic              ctrl_tx_en, ctrl_loop;
  logic              st_tx_done, st_tx_ovf, st_rx_ovf;
  logic [3:0]        ie;
  logic              w_status;
  logic              unused_bits;

  assign unused_bits = ^{address[1:0], wdata};

  assign tx_empty = (tx_count == '0);
  assign tx_full  = (tx_count == TX_FULL_CNT);
  assign tx_wr    = we && (index == 3'd0);
  assign tx_pop   = tx_done && !tx_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign tx_push  = tx_wr && (!tx_full || tx_pop);
  assign tx_data  = tx_empty ? '0 : tx_mem[tx_rd_ptr];
  assign tx_start = ctrl_tx_en && !tx_empty;

`ifdef UART_LOOPBACK_EN
  assign rx_in_valid = ctrl_loop ? tx_pop : rx_done;
  assign rx_in_data  = ctrl_loop ? tx_data : rx_data;
`else
  assign ctrl_loop   = 1'b0;
  assign rx_in_valid = rx_done;
  assign rx_in_data  = rx_data;
`endif

  assign rx_empty = (rx_count == '0);
  assign rx_full  = (rx_count == RX_FULL_CNT);
  assign rx_pop   = re && (index == 3'd3) && !rx_empty;
  assign rx_push  = rx_in_valid && (!rx_full || rx_pop);
  assign rx_head  = rx_mem[rx_rd_ptr];
  assign w_status = we && (index == 3'd4);

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= wdata[DATA_W-1:0];
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_in_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_wr_ptr  <= '0;
      tx_rd_ptr  <= '0;
      tx_count   <= '0;
      rx_wr_ptr  <= '0;
      rx_rd_ptr  <= '0;
      rx_count   <= '0;
      dvsr       <= '0;
      ctrl_tx_en <= 1'b0;
      stop2      <= 1'b0;
`ifdef UART_LOOPBACK_EN
      ctrl_loop  <= 1'b0;
`endif
      ie         <= '0;
      st_tx_done <= 1'b0;
      st_tx_ovf  <= 1'b0;
      st_rx_ovf  <= 1'b0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      if (tx_push && !tx_pop)      tx_count <= tx_count + 1'b1;
      else if (tx_pop && !tx_push) tx_count <= tx_count - 1'b1;

      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      if (rx_push && !rx_pop)      rx_count <= rx_count + 1'b1;
      else if (rx_pop && !rx_push) rx_count <= rx_count - 1'b1;

      if (we && index == 3'd1) dvsr <= wdata[DVSR_W-1:0];
      if (we && index == 3'd2) begin
        ctrl_tx_en <= wdata[0];
        stop2      <= wdata[1];
`ifdef UART_LOOPBACK_EN
        ctrl_loop  <= wdata[2];
`endif
      end
      if (we && index == 3'd5) ie <= wdata[3:0];

      // Set terms are OR-ed after the clear so a same-cycle event beats the W1C.
      st_tx_done <= tx_done || (st_tx_done && !(w_status && wdata[0]));
      st_tx_ovf  <= (tx_wr && tx_full && !tx_pop) || (st_tx_ovf && !(w_status && wdata[2]));
      st_rx_ovf  <= (rx_in_valid && rx_full && !rx_pop) || (st_rx_ovf && !(w_status && wdata[3]));
    end
  end

  always_comb begin
    rdata = '0;
    case (index)
      3'd0: begin
        rdata     = 32'(tx_count);
        rdata[31] = tx_full;
        rdata[30] = tx_empty;
      end
      3'd1: rdata = 32'(dvsr);
      3'd2: rdata = {29'd0, ctrl_loop, stop2, ctrl_tx_en};
      3'd3: begin
        if (!rx_empty) begin
          rdata     = 32'(rx_head);
          rdata[31] = 1'b1;
        end
      end
      3'd4: rdata = {26'd0, rx_full, tx_full, st_rx_ovf, st_tx_ovf, !rx_empty, st_tx_done};
      3'd5: rdata = {28'd0, ie};
      default: rdata = '0;
    endcase
  end

  assign tx_int = ie[0] && st_tx_done;
  assign rx_int = |(ie[3:1] & {st_rx_ovf, st_tx_ovf, !rx_empty});
endmodule

// File: tb/tb_uart_csr_fifo.sv
// Directed bench for uart_csr_fifo: vector table for register/FIFO basics, hand sequences for
// FIFO full/overflow, simultaneous push+pop, mid-transfer reset and (when built) loopback.
module tb_uart_csr_fifo;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        we, re, tx_done, rx_done;
  logic [4:0]  address;
  logic [31:0] wdata, rdata;
  logic [7:0]  tx_data, rx_data;
  logic        tx_start, stop2, tx_int, rx_int;
  logic [10:0] dvsr;

  int checks = 0;
  int failures = 0;

`ifdef UART_LOOPBACK_EN
  localparam logic [31:0] CTRL7_RB = 32'h7;
`else
  localparam logic [31:0] CTRL7_RB = 32'h3;
`endif

  uart_csr_fifo dut (
    .clk(clk), .rst_n(rst_n), .we(we), .re(re), .address(address), .wdata(wdata),
    .rdata(rdata), .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done), .dvsr(dvsr),
    .stop2(stop2), .rx_data(rx_data), .rx_done(rx_done), .tx_int(tx_int), .rx_int(rx_int)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        re;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        txd;
    logic        rxd;
    logic [7:0]  rxv;
    logic [31:0] exp_rdata;
    logic        exp_start;
    logic [7:0]  exp_txdata;
    logic        exp_tx_int;
    logic        exp_rx_int;
  } vec_t;

  vec_t vecs[25];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One bus cycle: inputs held from this negedge to the next, outputs sampled 1ns later (pre-edge state).
  task automatic step(input logic w, input logic r, input logic [4:0] a, input logic [31:0] d,
                      input logic txd, input logic rxd, input logic [7:0] rxv);
    @(negedge clk);
    we = w; re = r; address = a; wdata = d; tx_done = txd; rx_done = rxd; rx_data = rxv;
    #1;
  endtask

  task automatic rd(input logic [4:0] a);
    step(1'b0, 1'b0, a, 32'h0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    step(1'b1, 1'b0, a, d, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    //           we re addr   wdata         txd rxd rxv     rdata         st txdata txi rxi
    vecs[0]  = '{0, 0, 5'h00, 32'h0,        0, 0, 8'h00, 32'h4000_0000, 0, 8'h00, 0, 0};
    vecs[1]  = '{1, 0, 5'h00, 32'h41,       0, 0, 8'h00, 32'h4000_0000, 0, 8'h00, 0, 0};
    vecs[2]  = '{1, 0, 5'h00, 32'h42,       0, 0, 8'h00, 32'h0000_0001, 0, 8'h41, 0, 0};
    vecs[3]  = '{1, 0, 5'h08, 32'h1,        0, 0, 8'h00, 32'h0000_0000, 0, 8'h41, 0, 0};
    vecs[4]  = '{1, 0, 5'h14, 32'h1,        0, 0, 8'h00, 32'h0000_0000, 1, 8'h41, 0, 0};
    vecs[5]  = '{0, 0, 5'h10, 32'h0,        1, 0, 8'h00, 32'h0000_0000, 1, 8'h41, 0, 0};
    vecs[6]  = '{0, 0, 5'h10, 32'h0,        0, 0, 8'h00, 32'h0000_0001, 1, 8'h42, 1, 0};
    vecs[7]  = '{1, 0, 5'h10, 32'h1,        0, 0, 8'h00, 32'h0000_0001, 1, 8'h42, 1, 0};
    vecs[8]  = '{0, 0, 5'h00, 32'h0,        0, 0, 8'h00, 32'h0000_0001, 1, 8'h42, 0, 0};
    vecs[9]  = '{0, 0, 5'h00, 32'h0,        1, 0, 8'h00, 32'h0000_0001, 1, 8'h42, 0, 0};
    vecs[10] = '{0, 0, 5'h00, 32'h0,        1, 0, 8'h00, 32'h4000_0000, 0, 8'h00, 1, 0};
    vecs[11] = '{1, 0, 5'h10, 32'h1,        1, 0, 8'h00, 32'h0000_0001, 0, 8'h00, 1, 0};
    vecs[12] = '{1, 0, 5'h10, 32'h1,        0, 0, 8'h00, 32'h0000_0001, 0, 8'h00, 1, 0};
    vecs[13] = '{0, 0, 5'h10, 32'h0,        0, 0, 8'h00, 32'h0000_0000, 0, 8'h00, 0, 0};
    vecs[14] = '{1, 0, 5'h04, 32'hFFFF_FFFF, 0, 0, 8'h00, 32'h0000_0000, 0, 8'h00, 0, 0};
    vecs[15] = '{1, 0, 5'h08, 32'h3,        0, 0, 8'h00, 32'h0000_0001, 0, 8'h00, 0, 0};
    vecs[16] = '{0, 0, 5'h08, 32'h0,        0, 0, 8'h00, 32'h0000_0003, 0, 8'h00, 0, 0};
    vecs[17] = '{1, 0, 5'h18, 32'hFFFF_FFFF, 0, 0, 8'h00, 32'h0000_0000, 0, 8'h00, 0, 0};
    vecs[18] = '{1, 0, 5'h1C, 32'hFFFF_FFFF, 0, 0, 8'h00, 32'h0000_0000, 0, 8'h00, 0, 0};
    vecs[19] = '{1, 0, 5'h14, 32'h2,        0, 1, 8'h5A, 32'h0000_0001, 0, 8'h00, 0, 0};
    vecs[20] = '{0, 0, 5'h0C, 32'h0,        0, 1, 8'hA5, 32'h8000_005A, 0, 8'h00, 0, 1};
    vecs[21] = '{0, 1, 5'h0C, 32'h0,        0, 0, 8'h00, 32'h8000_005A, 0, 8'h00, 0, 1};
    vecs[22] = '{0, 1, 5'h0C, 32'h0,        0, 0, 8'h00, 32'h8000_00A5, 0, 8'h00, 0, 1};
    vecs[23] = '{0, 1, 5'h0C, 32'h0,        0, 0, 8'h00, 32'h0000_0000, 0, 8'h00, 0, 0};
    vecs[24] = '{0, 0, 5'h10, 32'h0,        0, 0, 8'h00, 32'h0000_0000, 0, 8'h00, 0, 0};

    // Reset
    rst_n = 1'b0; we = 0; re = 0; address = '0; wdata = '0; tx_done = 0; rx_done = 0; rx_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset dvsr", 32'(dvsr), 32'h0);
    chk("reset stop2", 32'(stop2), 32'h0);

    foreach (vecs[i]) begin
      step(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata, vecs[i].txd, vecs[i].rxd, vecs[i].rxv);
      chk($sformatf("row%0d rdata", i), rdata, vecs[i].exp_rdata);
      chk($sformatf("row%0d tx_start", i), 32'(tx_start), 32'(vecs[i].exp_start));
      chk($sformatf("row%0d tx_data", i), 32'(tx_data), 32'(vecs[i].exp_txdata));
      chk($sformatf("row%0d tx_int", i), 32'(tx_int), 32'(vecs[i].exp_tx_int));
      chk($sformatf("row%0d rx_int", i), 32'(rx_int), 32'(vecs[i].exp_rx_int));
    end
    chk("dvsr out", 32'(dvsr), 32'h7FF);
    chk("stop2 out", 32'(stop2), 32'h1);

    // CTRL[2] only sticks when loopback is built
    wr(5'h08, 32'h7);
    rd(5'h08);
    chk("ctrl bit2", rdata, CTRL7_RB);

    // TX overflow with tx_en off: 9 writes, the 9th is dropped
    wr(5'h08, 32'h2);
    for (int i = 0; i < 9; i++) wr(5'h00, 32'h10 + 32'(i));
    rd(5'h00);
    chk("tx full count", rdata, 32'h8000_0008);
    chk("tx_start off", 32'(tx_start), 32'h0);
    rd(5'h10);
    chk("tx ovf status", rdata, 32'h0000_0014);
    wr(5'h14, 32'h4);
    rd(5'h10);
    chk("rx_int tx_ovf", 32'(rx_int), 32'h1);
    wr(5'h10, 32'h4);
    rd(5'h10);
    chk("tx_ovf cleared", rdata, 32'h0000_0010);
    chk("rx_int cleared", 32'(rx_int), 32'h0);
    // push and pop together while full
    step(1'b1, 1'b0, 5'h00, 32'h77, 1'b1, 1'b0, 8'h00);
    rd(5'h00);
    chk("tx full push+pop count", rdata, 32'h8000_0008);
    rd(5'h10);
    chk("tx full push+pop status", rdata, 32'h0000_0011);
    wr(5'h08, 32'h3);
    rd(5'h00);
    chk("tx_start on", 32'(tx_start), 32'h1);
    for (int i = 1; i < 8; i++) begin
      step(1'b0, 1'b0, 5'h00, 32'h0, 1'b1, 1'b0, 8'h00);
      chk($sformatf("tx drain %0d", i), 32'(tx_data), 32'h10 + 32'(i));
    end
    step(1'b0, 1'b0, 5'h00, 32'h0, 1'b1, 1'b0, 8'h00);
    chk("tx drain last", 32'(tx_data), 32'h77);
    rd(5'h00);
    chk("tx drained empty", rdata, 32'h4000_0000);
    chk("tx drained data", 32'(tx_data), 32'h0);
    chk("tx drained start", 32'(tx_start), 32'h0);

    // RX full with simultaneous push and pop, then RX overflow
    wr(5'h10, 32'hD);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 5'h10, 32'h0, 1'b0, 1'b1, 8'h60 + 8'(i));
    rd(5'h10);
    chk("rx full status", rdata, 32'h0000_0022);
    step(1'b0, 1'b1, 5'h0C, 32'h0, 1'b0, 1'b1, 8'h99);
    chk("rx pop at full", rdata, 32'h8000_0060);
    rd(5'h10);
    chk("rx push+pop no ovf", rdata, 32'h0000_0022);
    for (int i = 1; i < 8; i++) begin
      step(1'b0, 1'b1, 5'h0C, 32'h0, 1'b0, 1'b0, 8'h00);
      chk($sformatf("rx drain %0d", i), rdata, 32'h8000_0060 + 32'(i));
    end
    step(1'b0, 1'b1, 5'h0C, 32'h0, 1'b0, 1'b0, 8'h00);
    chk("rx drain 99", rdata, 32'h8000_0099);
    step(1'b0, 1'b1, 5'h0C, 32'h0, 1'b0, 1'b0, 8'h00);
    chk("rx drain empty", rdata, 32'h0);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 5'h10, 32'h0, 1'b0, 1'b1, 8'h70 + 8'(i));
    rd(5'h10);
    chk("rx ovf status", rdata, 32'h0000_002A);
    wr(5'h14, 32'h8);
    rd(5'h10);
    chk("rx_int rx_ovf", 32'(rx_int), 32'h1);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 5'h0C, 32'h0, 1'b0, 1'b0, 8'h00);
      chk($sformatf("rx ovf drain %0d", i), rdata, 32'h8000_0070 + 32'(i));
    end
    step(1'b0, 1'b1, 5'h0C, 32'h0, 1'b0, 1'b0, 8'h00);
    chk("rx ovf 9th dropped", rdata, 32'h0);
    wr(5'h10, 32'h8);
    rd(5'h10);
    chk("rx_ovf cleared", rdata, 32'h0);
    chk("rx_int off", 32'(rx_int), 32'h0);

    // Reset with TX data pending flushes the FIFO
    wr(5'h00, 32'hC1);
    wr(5'h00, 32'hC2);
    rd(5'h00);
    chk("pre-reset count", rdata, 32'h0000_0002);
    chk("pre-reset start", 32'(tx_start), 32'h1);
    @(negedge clk);
    rst_n = 1'b0; we = 0; re = 0; address = '0; tx_done = 0; rx_done = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid reset start", 32'(tx_start), 32'h0);
    chk("mid reset flush", rdata, 32'h4000_0000);
    chk("mid reset dvsr", 32'(dvsr), 32'h0);

`ifdef UART_LOOPBACK_EN
    wr(5'h08, 32'h5);
    step(1'b0, 1'b0, 5'h0C, 32'h0, 1'b0, 1'b1, 8'hEE);
    wr(5'h00, 32'h33);
    rd(5'h00);
    chk("loopback tx_start", 32'(tx_start), 32'h1);
    step(1'b0, 1'b0, 5'h0C, 32'h0, 1'b1, 1'b0, 8'h00);
    chk("loopback ext ignored", rdata, 32'h0);
    step(1'b0, 1'b1, 5'h0C, 32'h0, 1'b0, 1'b0, 8'h00);
    chk("loopback rxdata", rdata, 32'h8000_0033);
    step(1'b0, 1'b1, 5'h0C, 32'h0, 1'b0, 1'b0, 8'h00);
    chk("loopback rx empty", rdata, 32'h0);
`endif

    rd(5'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
